// File: rtl/arb_pkg.sv
// Shared types for the hold-capable round-robin arbiter.
package arb_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for an n-port arbiter; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fixed_prio_arb.sv
// Combinational fixed-priority arbiter: lowest set request index wins, one-hot out.
module fixed_prio_arb #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt
);
    // Two's-complement trick isolates the lowest set bit.
    assign gnt = req & (~req + NUM_PORTS'(1));
endmodule

// File: rtl/rr_arbiter_hold.sv
// Registered round-robin arbiter; a winner keeps its grant while requesting,
// capped at MAX_HOLD cycles per tenure.
module rr_arbiter_hold
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_PORTS-1:0]                req_i,
    output logic [NUM_PORTS-1:0]                gnt_o,
    output logic                                gnt_valid_o,
    output logic [id_width(NUM_PORTS)-1:0]      gnt_id_o
);
    localparam int IW = id_width(NUM_PORTS);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] LAST_ID   = IW'(NUM_PORTS - 1);

    arb_state_e           state_q, state_d;
    logic [CW-1:0]        hold_q, hold_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        id_q, id_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic                 vld_q;

    logic [NUM_PORTS-1:0] mask, req_masked, gnt_masked, gnt_unmasked, rr_gnt;
    logic [IW-1:0]        rr_id;
    logic                 pick;

    // Ports at or above ptr get first chance; the wrap-around falls back to the plain request.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            mask[i] = (i >= int'(ptr_q));
    end

    assign req_masked = req_i & mask;

    fixed_prio_arb #(.NUM_PORTS(NUM_PORTS)) u_arb_masked (
        .req (req_masked),
        .gnt (gnt_masked)
    );

    fixed_prio_arb #(.NUM_PORTS(NUM_PORTS)) u_arb_unmasked (
        .req (req_i),
        .gnt (gnt_unmasked)
    );

    assign rr_gnt = (|gnt_masked) ? gnt_masked : gnt_unmasked;

    always_comb begin
        rr_id = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (rr_gnt[i]) rr_id = IW'(i);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        gnt_d   = gnt_q;
        pick    = 1'b0;
        case (state_q)
            IDLE:  pick = 1'b1;
            GRANT: begin
                if (!req_i[id_q] || hold_q == HOLD_LAST) pick = 1'b1;
                else                                     hold_d = hold_q + CW'(1);
            end
            default: pick = 1'b1;
        endcase
        // ptr already sits one past the released owner, so it competes at lowest priority.
        if (pick) begin
            if (|rr_gnt) begin
                state_d = GRANT;
                gnt_d   = rr_gnt;
                id_d    = rr_id;
                hold_d  = '0;
                ptr_d   = (rr_id == LAST_ID) ? '0 : rr_id + IW'(1);
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            vld_q   <= |gnt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = vld_q;
    assign gnt_id_o    = id_q;
endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: directed cycle tables, reset corner, randomized run vs. reference model.
module tb_rr_arbiter_hold;
    localparam int NP = 4;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] gnt;
    logic          gnt_valid;
    logic [1:0]    gnt_id;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] gnt;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter_hold #(.NUM_PORTS(NP), .MAX_HOLD(MH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] idx_of(input logic [NP-1:0] g);
        logic [31:0] r = 0;
        for (int i = 0; i < NP; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Leaves the bench on a negedge with reset released; the next posedge starts cycle 0.
    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_valid", 32'(gnt_valid), 0);
        chk("reset_id", 32'(gnt_id), 0);
        reset_n = 1'b1;
    endtask

    task automatic add(input logic [NP-1:0] r, input logic [NP-1:0] g, input int n);
        vec_t v;
        v.req = r;
        v.gnt = g;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic run_table(input string nm);
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1 req = tbl[i].req;
            @(negedge clk);
            chk($sformatf("%s_gnt_c%0d", nm, i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("%s_vld_c%0d", nm, i), 32'(gnt_valid), 32'(|tbl[i].gnt));
            chk($sformatf("%s_id_c%0d", nm, i), 32'(gnt_id), idx_of(tbl[i].gnt));
        end
        tbl.delete();
    endtask

    // Reference model: owner (-1 = none), cycles served in current tenure, next-search start.
    int m_owner, m_served, m_ptr;

    task automatic model_reset();
        m_owner = -1;
        m_served = 0;
        m_ptr = 0;
    endtask

    task automatic model_edge(input logic [NP-1:0] r);
        bit choose = 1'b0;
        if (m_owner < 0) choose = 1'b1;
        else if (!r[m_owner] || m_served == MH) choose = 1'b1;
        else m_served++;
        if (choose) begin
            int start = m_ptr;
            m_owner = -1;
            for (int j = 0; j < NP; j++) begin
                int p = (start + j) % NP;
                if (r[p] && m_owner < 0) begin
                    m_owner = p;
                    m_served = 1;
                    m_ptr = (p + 1) % NP;
                end
            end
        end
    endtask

    initial begin
        // Idle: no requests for 20 cycles.
        add(4'b0000, 4'b0000, 20);
        run_table("idle");

        // Alternating back-to-back tenures, no bubbles.
        add(4'b0000, 4'b0000, 1);
        add(4'b0101, 4'b0000, 1);
        add(4'b0101, 4'b0001, 4);
        add(4'b0101, 4'b0100, 4);
        add(4'b0101, 4'b0001, 4);
        add(4'b0101, 4'b0100, 1);
        run_table("alt");

        // Sole requester regranted across expiries without a gap.
        add(4'b0000, 4'b0000, 1);
        add(4'b0010, 4'b0000, 1);
        add(4'b0010, 4'b0010, 11);
        run_table("sole");

        // Owner drops request: one-cycle overlap, then next port.
        add(4'b0000, 4'b0000, 1);
        add(4'b1111, 4'b0000, 1);
        add(4'b1111, 4'b0001, 2);
        add(4'b1110, 4'b0001, 1);
        add(4'b1110, 4'b0010, 4);
        add(4'b1110, 4'b0100, 1);
        run_table("drop");

        // Owner 3 expires: wrap to port 0, then port 3 again.
        add(4'b0000, 4'b0000, 1);
        add(4'b1000, 4'b0000, 1);
        add(4'b1001, 4'b1000, 4);
        add(4'b1001, 4'b0001, 4);
        add(4'b1001, 4'b1000, 4);
        add(4'b1001, 4'b0001, 1);
        run_table("wrap");

        // Asynchronous reset mid-tenure, then ptr must be back at 0.
        do_reset();
        @(posedge clk);
        #1 req = 4'b0000;
        @(posedge clk);
        #1 req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        chk("areset_pre_gnt", 32'(gnt), 32'h4);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("areset_gnt", 32'(gnt), 0);
        chk("areset_vld", 32'(gnt_valid), 0);
        chk("areset_id", 32'(gnt_id), 0);
        req = 4'b1100;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("areset_after_gnt", 32'(gnt), 32'h4);
        chk("areset_after_id", 32'(gnt_id), 2);

        // Randomized sticky requests vs. reference model, plus fairness bound.
        begin
            int wait_cnt[NP];
            int max_wait = 0;
            logic [NP-1:0] exp_g;
            do_reset();
            model_reset();
            for (int i = 0; i < NP; i++) wait_cnt[i] = 0;
            for (int c = 0; c < 600; c++) begin
                @(posedge clk);
                model_edge(req);
                #1;
                for (int i = 0; i < NP; i++)
                    if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                @(negedge clk);
                exp_g = '0;
                if (m_owner >= 0) exp_g[m_owner] = 1'b1;
                chk($sformatf("rand_gnt_c%0d", c), 32'(gnt), 32'(exp_g));
                chk($sformatf("rand_vld_c%0d", c), 32'(gnt_valid), 32'(m_owner >= 0));
                chk($sformatf("rand_id_c%0d", c), 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 0);
                for (int i = 0; i < NP; i++) begin
                    if (req[i] && !gnt[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                    if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                end
            end
            chk("fairness_bound", 32'(max_wait <= (NP - 1) * MH + 1), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
